// File: rtl/fft_pkg.sv
// +--------------------------------------------------------------------+
// | fft_pkg: shared constants, scheduler state type and bin bit-reverse |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package fft_pkg;

   localparam int LOG2N = 4;
   localparam int N     = 2 ** LOG2N;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // Reverses the low w bits of v; bits at and above w come back as zero.
   function automatic logic [15:0] bitrev(input logic [15:0] v, input int w);
      logic [15:0] r;
      r = '0;
      for (int i = 0; i < 16; i++) begin
         if (i < w) r = r | (((v >> i) & 16'd1) << (w - 1 - i));
      end
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/fft_fill_tracker.sv
// +--------------------------------------------------------------------+
// | fft_fill_tracker: pipeline fill (primed) and flush drain counters   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module fft_fill_tracker
   import fft_pkg::*;
#(
   parameter int LAT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ce_i,
   input  logic clear_i,
   input  logic drain_load_i,
   input  logic drain_ce_i,
   output logic primed_o,
   output logic drain_last_o
);

   localparam logic [7:0] LAT_C = 8'(LAT);

   logic [7:0] fill_cnt_q, fill_cnt_d;
   logic [7:0] drain_cnt_q, drain_cnt_d;

   always_comb begin
      fill_cnt_d = fill_cnt_q;
      if (clear_i)
         fill_cnt_d = '0;
      else if (ce_i && (fill_cnt_q != LAT_C))
         fill_cnt_d = fill_cnt_q + 8'd1;
   end

   always_comb begin
      drain_cnt_d = drain_cnt_q;
      if (drain_load_i)
         drain_cnt_d = LAT_C;
      else if (drain_ce_i && (drain_cnt_q != 8'd0))
         drain_cnt_d = drain_cnt_q - 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fill_cnt_q  <= '0;
         drain_cnt_q <= '0;
      end else begin
         fill_cnt_q  <= fill_cnt_d;
         drain_cnt_q <= drain_cnt_d;
      end
   end

   assign primed_o     = (fill_cnt_q == LAT_C);
   assign drain_last_o = (drain_cnt_q == 8'd1);

endmodule

`default_nettype wire

// File: rtl/fft_stream_scheduler.sv
// +--------------------------------------------------------------------+
// | fft_stream_scheduler: valid/ready sequencer for a radix-2 SDF FFT   |
// | Optional statistics outputs under `FFT_SCHED_STATS_EN`.            |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module fft_stream_scheduler
   import fft_pkg::*;
#(
   parameter int LOG2N = fft_pkg::LOG2N,
   parameter int LAT   = 15,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             flush_req,
   input  logic             out_ready,
   output logic             ce_o,
   output logic             zero_inj_o,
   output logic [LOG2N-1:0] sel_o,
   output logic             out_valid,
   output logic [LOG2N-1:0] out_idx,
   output logic             out_first,
   output logic             out_last,
   output logic             busy
`ifdef FFT_SCHED_STATS_EN
   ,
   output logic [CNT_W-1:0] frame_cnt_o,
   output logic [CNT_W-1:0] stall_cnt_o
`endif
);

   localparam logic [LOG2N-1:0] CNT_MAX = '1;

   if ((LAT < 1) || (LAT > 255) || (CNT_W < 1) || (LOG2N < 2) || (LOG2N > 16)) begin : g_param_check
      $error("fft_stream_scheduler: parameter out of range");
   end

   state_t           state_q, state_d;
   logic [LOG2N-1:0] in_cnt_q, in_cnt_d;
   logic [LOG2N-1:0] out_cnt_q, out_cnt_d;
   logic [LOG2N-1:1] sel_q, sel_d;
   logic             flush_q, flush_d;
   logic             primed, drain_last;
   logic             accept, drain_ce, enter_drain, leave_drain;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // The wrap-accept term lets DRAIN start right after the last sample of the frame.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) state_d = RUN;
         end
         RUN: begin
            if ((flush_q || flush_req) && accept && (in_cnt_q == CNT_MAX))
               state_d = DRAIN;
            else if (flush_q && (in_cnt_q == '0) && !accept)
               state_d = DRAIN;
         end
         DRAIN: begin
            if (drain_ce && drain_last) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready   = (state_q != DRAIN) && (out_ready || !primed);
      zero_inj_o = (state_q == DRAIN);
      busy       = (state_q != IDLE);
      ce_o       = (in_valid && in_ready) || (zero_inj_o && out_ready);
   end

   assign accept      = in_valid && in_ready;
   assign drain_ce    = zero_inj_o && ce_o;
   assign enter_drain = (state_q == RUN) && (state_d == DRAIN);
   assign leave_drain = (state_q == DRAIN) && (state_d == IDLE);

   always_comb begin
      flush_d   = flush_q;
      in_cnt_d  = in_cnt_q;
      out_cnt_d = out_cnt_q;
      sel_d     = sel_q;
      if (enter_drain)
         flush_d = 1'b0;
      else if (flush_req && (state_q == RUN))
         flush_d = 1'b1;
      if (leave_drain) begin
         in_cnt_d  = '0;
         out_cnt_d = '0;
         sel_d     = '0;
      end else begin
         // Upper selects lag in_cnt by one ce to line up with the registered first butterfly.
         if (ce_o) begin
            in_cnt_d = in_cnt_q + 1'b1;
            sel_d    = in_cnt_q[LOG2N-1:1];
         end
         if (out_valid && out_ready)
            out_cnt_d = out_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flush_q   <= 1'b0;
         in_cnt_q  <= '0;
         out_cnt_q <= '0;
         sel_q     <= '0;
      end else begin
         flush_q   <= flush_d;
         in_cnt_q  <= in_cnt_d;
         out_cnt_q <= out_cnt_d;
         sel_q     <= sel_d;
      end
   end

   fft_fill_tracker #(
      .LAT (LAT)
   ) u_fill (
      .clk          (clk),
      .rst_n        (rst_n),
      .ce_i         (ce_o),
      .clear_i      (leave_drain),
      .drain_load_i (enter_drain),
      .drain_ce_i   (drain_ce),
      .primed_o     (primed),
      .drain_last_o (drain_last)
   );

   assign sel_o     = {sel_q, in_cnt_q[0]};
   assign out_valid = ce_o && primed;
   assign out_idx   = LOG2N'(bitrev(16'(out_cnt_q), LOG2N));
   assign out_first = out_valid && (out_cnt_q == '0);
   assign out_last  = out_valid && (out_cnt_q == CNT_MAX);

`ifdef FFT_SCHED_STATS_EN
   logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      frame_cnt_d = frame_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (out_last && out_ready && (frame_cnt_q != '1))
         frame_cnt_d = frame_cnt_q + 1'b1;
      if (in_valid && !in_ready && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign frame_cnt_o = frame_cnt_q;
   assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fft_stream_scheduler.sv
// +--------------------------------------------------------------------+
// | tb_fft_stream_scheduler: directed scoreboard bench for the scheduler|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_fft_stream_scheduler;

   localparam int LAT = 15;
   localparam int NB  = fft_pkg::N;

   typedef struct packed {
      logic [3:0] idx;
      logic       first;
      logic       last;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n, in_valid, flush_req, out_ready;
   logic       in_ready, ce_o, zero_inj_o, out_valid, out_first, out_last, busy;
   logic [3:0] sel_o, out_idx;
`ifdef FFT_SCHED_STATS_EN
   logic [15:0] frame_cnt, stall_cnt;
`endif

   int         errors = 0;
   int         checks = 0;
   exp_t       sb_q[$];
   int         k_push, acc_total, first_valid_acc, drain_ce, last_dl, acc0;
   int         exp_rdy, exp_ce;
   logic [3:0] m_in, m_last, sel_hold;
   logic       chk_sel;

   always #5 clk = ~clk;

   fft_stream_scheduler #(
      .LOG2N (4),
      .LAT   (LAT),
      .CNT_W (16)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .flush_req  (flush_req),
      .out_ready  (out_ready),
      .ce_o       (ce_o),
      .zero_inj_o (zero_inj_o),
      .sel_o      (sel_o),
      .out_valid  (out_valid),
      .out_idx    (out_idx),
      .out_first  (out_first),
      .out_last   (out_last),
      .busy       (busy)
`ifdef FFT_SCHED_STATS_EN
      ,
      .frame_cnt_o (frame_cnt),
      .stall_cnt_o (stall_cnt)
`endif
   );

   function automatic logic [3:0] rev4(input logic [3:0] v);
      return {v[0], v[1], v[2], v[3]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: settle, check, record handshakes into the scoreboard, advance the model.
   task automatic tick();
      exp_t e;
      #1;
      if (chk_sel) chk("sel_o", 32'(sel_o), 32'({m_last[3:1], m_in[0]}));
      if (exp_rdy >= 0) chk("in_ready", 32'(in_ready), exp_rdy);
      if (exp_ce >= 0) chk("ce_o", 32'(ce_o), exp_ce);
      if (in_valid && in_ready) begin
         e.idx   = rev4(4'(k_push));
         e.first = ((k_push % NB) == 0);
         e.last  = ((k_push % NB) == NB - 1);
         sb_q.push_back(e);
         k_push++;
         acc_total++;
      end
      if (out_valid) begin
         if (first_valid_acc == 0) first_valid_acc = acc_total;
         if (sb_q.size() == 0) begin
            chk("sb_underflow", 32'(sb_q.size()), 1);
         end else begin
            e = sb_q.pop_front();
            chk("out_idx", 32'(out_idx), 32'(e.idx));
            chk("out_first", 32'(out_first), 32'(e.first));
            chk("out_last", 32'(out_last), 32'(e.last));
         end
      end else begin
         chk("flags_without_valid", 32'({out_first, out_last}), 0);
      end
      if (ce_o) begin
         m_last = m_in;
         m_in   = m_in + 4'd1;
      end
      if (zero_inj_o && ce_o) begin
         drain_ce++;
         if (out_last) last_dl = drain_ce;
         if (drain_ce == LAT) begin
            m_in   = '0;
            m_last = '0;
            k_push = 0;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; flush_req = 1'b0; out_ready = 1'b1;
      chk_sel = 1'b0; exp_rdy = -1; exp_ce = -1;
      k_push = 0; acc_total = 0; first_valid_acc = 0; drain_ce = 0; last_dl = 0;
      m_in = '0; m_last = '0;

      // Reset values
      repeat (3) @(negedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_ce", 32'(ce_o), 0);
      chk("rst_sel", 32'(sel_o), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_idx", 32'(out_idx), 0);
      chk("rst_first_last", 32'({out_first, out_last}), 0);
      chk("rst_zero_inj", 32'(zero_inj_o), 0);
      chk("rst_busy", 32'(busy), 0);
`ifdef FFT_SCHED_STATS_EN
      chk("rst_frame_cnt", 32'(frame_cnt), 0);
      chk("rst_stall_cnt", 32'(stall_cnt), 0);
`endif
      @(negedge clk);

      // Continuous streaming
      rst_n = 1'b1; in_valid = 1'b1; chk_sel = 1'b1; exp_rdy = 1;
      for (int i = 0; i < 40; i++) tick();
      chk("first_valid_at_accept", first_valid_acc, 16);
      chk("busy_run", 32'(busy), 1);

      // Downstream stall while primed
      sel_hold = sel_o; out_ready = 1'b0; exp_rdy = 0; exp_ce = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("stall_sel_hold", 32'(sel_o), 32'(sel_hold));
         chk("stall_out_valid", 32'(out_valid), 0);
      end
`ifdef FFT_SCHED_STATS_EN
      chk("stall_cnt", 32'(stall_cnt), 5);
`endif
      out_ready = 1'b1; exp_rdy = 1; exp_ce = 1;
      for (int i = 0; i < 20; i++) tick();

      // Input gaps: one on, two off
      for (int r = 0; r < 8; r++) begin
         in_valid = 1'b1; exp_ce = 1; tick();
         in_valid = 1'b0; exp_ce = 0; tick(); tick();
      end
      in_valid = 1'b1; exp_ce = -1; exp_rdy = -1;

      // Mid-frame flush at in_cnt=5
      for (int i = 0; i < 32 && m_in != 4'd5; i++) tick();
      chk("align_in_cnt_5", 32'(m_in), 5);
      acc0 = acc_total; flush_req = 1'b1; tick(); flush_req = 1'b0;
      for (int i = 0; i < 40 && zero_inj_o !== 1'b1; i++) tick();
      chk("drain_entered", 32'(zero_inj_o), 1);
      chk("accepts_after_flush", acc_total - acc0, 11);
      chk("in_ready_in_drain", 32'(in_ready), 0);
      drain_ce = 0; last_dl = 0;
      tick(); tick();
      flush_req = 1'b1; tick(); flush_req = 1'b0;
      for (int i = 0; i < 100 && busy === 1'b1; i++) tick();
      chk("drain_ce_cycles", drain_ce, 15);
      chk("last_out_last_drain_cycle", last_dl, 15);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_zero_inj", 32'(zero_inj_o), 0);
      chk("idle_in_ready", 32'(in_ready), 1);
      chk("sb_empty_after_drain", 32'(sb_q.size()), 0);

      // Flush while IDLE is ignored
      in_valid = 1'b0; flush_req = 1'b1; tick(); flush_req = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      chk("idle_flush_ignored", 32'(zero_inj_o), 0);
      chk("idle_flush_busy", 32'(busy), 1);

      // Flush coincident with the last-sample accept, then reset during DRAIN
      for (int i = 0; i < 32 && m_in != 4'd15; i++) tick();
      chk("align_in_cnt_15", 32'(m_in), 15);
      flush_req = 1'b1; tick(); flush_req = 1'b0;
      chk("drain_next_cycle", 32'(zero_inj_o), 1);
      tick(); tick(); tick();
      rst_n = 1'b0; in_valid = 1'b0;
      #1;
      chk("rstd_zero_inj", 32'(zero_inj_o), 0);
      chk("rstd_busy", 32'(busy), 0);
      chk("rstd_in_ready", 32'(in_ready), 1);
      chk("rstd_ce", 32'(ce_o), 0);
      chk("rstd_out_valid", 32'(out_valid), 0);
      chk("rstd_sel", 32'(sel_o), 0);
      chk("rstd_out_idx", 32'(out_idx), 0);
      chk("rstd_first_last", 32'({out_first, out_last}), 0);
`ifdef FFT_SCHED_STATS_EN
      chk("rstd_frame_cnt", 32'(frame_cnt), 0);
`endif
      sb_q.delete();
      m_in = '0; m_last = '0; k_push = 0; drain_ce = 0; last_dl = 0;
      @(negedge clk);

      // Three complete frames followed by a flush drain
      rst_n = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 60 && k_push < 47; i++) tick();
      chk("align_k47", k_push, 47);
      flush_req = 1'b1; tick(); flush_req = 1'b0;
      chk("drain3_entered", 32'(zero_inj_o), 1);
      for (int i = 0; i < 100 && busy === 1'b1; i++) tick();
      chk("drain3_ce_cycles", drain_ce, 15);
      chk("drain3_idle", 32'(busy), 0);
      chk("sb_empty_end", 32'(sb_q.size()), 0);
`ifdef FFT_SCHED_STATS_EN
      chk("frame_cnt_3", 32'(frame_cnt), 3);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/fft_stream_scheduler.md
Name: fft_stream_scheduler

Overview:
- Sequences the pipelined radix-2 single-path-delay-feedback (SDF) FFT datapath under valid/ready flow control.
- Generates the global clock-enable and the per-stage butterfly/delay selects. The selects advance only on accepted samples, so the datapath can stall.
- Tracks pipeline fill latency and marks output samples with valid, bit-reversed bin index and frame first/last.
- Drains the pipeline by injecting zeros on flush, so the final frame emerges without new input.

Parameters:
- LOG2N, 4, log2 of FFT size. N = 2**LOG2N; default is 16-point.
- LAT, 15, accepted-sample latency from datapath input to first valid output (N-1 for SDF). Range 1..255.
- CNT_W, 16, width of statistics counters (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream sample valid
- in_ready  out  1  scheduler accepts sample this cycle
- flush_req  in  1  single-cycle pulse: drain pipeline after the current frame
- out_ready  in  1  downstream accepts output
- ce_o  out  1  datapath clock enable; all datapath registers advance only when ce_o=1
- zero_inj_o  out  1  datapath muxes zero into the input (flush drain)
- sel_o  out  LOG2N  stage selects; bit i drives the stage with delay 2**i
- out_valid  out  1  datapath output sample valid this cycle
- out_idx  out  LOG2N  bit-reversed frequency bin of the output sample
- out_first  out  1  out_valid and out_idx is bin 0 of a frame
- out_last  out  1  out_valid and last sample of a frame (output counter = N-1)
- busy  out  1  state != IDLE

Behaviour:
- Reset:
  - Counters clear to 0; state IDLE; flush latch cleared.
  - sel_o, out_valid, out_idx, out_first, out_last, ce_o, zero_inj_o and busy are all 0.
  - in_ready = 1.
- Counters:
  - Input sample counter in_cnt[LOG2N-1:0] increments on ce_o and wraps at N-1 -> 0.
  - Output counter out_cnt increments on every out_valid&&out_ready handshake and wraps at N-1 -> 0.
  - Fill counter fill_cnt (8 bits) saturates at LAT. primed = (fill_cnt == LAT).
- Select timing:
  - sel_o[0] is combinational in_cnt[0].
  - sel_o[i] for i>=1 is register <= in_cnt[i], updated only when ce_o=1. This gives one ce-cycle of alignment with the registered first butterfly.
- States:
  - IDLE -> RUN on first accepted sample.
  - RUN -> DRAIN when the flush latch is set and in_cnt==0 with no accept in the same cycle (frame boundary).
  - DRAIN -> IDLE after LAT drain ce cycles, counted down by drain_cnt loaded with LAT on entry.
- Handshake and enable:
  - in_ready = (state != DRAIN) && (out_ready || !primed).
  - ce_o = (in_valid && in_ready) || (state == DRAIN && out_ready).
  - zero_inj_o = (state == DRAIN).
  - out_valid = ce_o && primed. The datapath output is combinational-consistent with this ce cycle.
- Flush rules:
  - A flush_req mid-frame is latched. Input acceptance continues until in_cnt wraps to 0, then DRAIN is entered; the frame is never split.
  - flush_req in IDLE is ignored.
  - A flush_req during DRAIN is ignored.
- Leaving DRAIN:
  - fill_cnt, in_cnt, out_cnt and the sel_o registers clear.
  - in_ready is reasserted the following cycle.
- Stall: out_ready=0 while primed freezes everything. ce_o=0, counters and sel_o hold, out_valid=0.
- Simultaneous flush_req and last-sample accept (in_cnt=N-1): the latch sets and DRAIN is entered the next cycle, when in_cnt==0.
- Reset mid-operation returns to the reset values immediately. The datapath is expected to share rst_n.

Optional Feature:
- Macro FFT_SCHED_STATS_EN.
- When defined, adds two outputs:
  - frame_cnt_o[CNT_W-1:0]: increments on each out_last handshake.
  - stall_cnt_o[CNT_W-1:0]: increments each cycle with in_valid=1 and in_ready=0.
- Both counters saturate at all-ones and reset to 0.
- When undefined, these ports and their logic do not exist.

Decomposition:
- Shared package fft_pkg holds:
  - LOG2N and N constants.
  - the state enum (IDLE, RUN, DRAIN).
  - a bit-reverse function, used for out_idx = bitrev(out_cnt).
- One natural sub-module is fft_fill_tracker: the fill, drain and primed logic, parameterised by LAT.

Test Plan:
- Reset release, in_valid held 1, out_ready=1 -> in_ready=1 every cycle. The first out_valid appears on the 16th accepted sample (LAT=15), with out_idx=0 and out_first=1. Subsequent out_idx follow 0,8,4,12,2,... and out_last comes with out_cnt=15.
- Continuous input: sel_o[3:1] toggle with period 16/8/4 accepted samples, delayed one ce relative to in_cnt bits. sel_o[0] alternates every accept.
- out_ready=0 for 5 cycles while primed -> ce_o=0, in_ready=0, sel_o and counters frozen. The sequence resumes identically afterwards.
- flush_req pulsed at in_cnt=5 -> 11 more samples are accepted, then DRAIN. zero_inj_o=1 for exactly 15 ce cycles, with the last out_last on drain cycle 15. Then IDLE and busy=0.
- in_valid gaps (1 on, 2 off) -> ce_o only on accept, and outputs match gapless ordering.
- Assert rst_n low during DRAIN -> all outputs return to reset values the same cycle. With FFT_SCHED_STATS_EN, frame_cnt_o=0 after reset and 3 after three completed frames.
